// File: rtl/fifo_mem_ctrl_if.sv
// Requester/memory-side bus of the FIFO memory controller.
// The master modport is the environment (requester plus memory); the slave is the controller.
interface fifo_mem_ctrl_if #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned ADDR_BITS = 6
);
   logic                 push;
   logic                 pop;
   logic [DATA_BITS-1:0] data_in;
   logic [DATA_BITS-1:0] mem_data_out;
   logic [DATA_BITS-1:0] mem_data_in;
   logic [ADDR_BITS-1:0] mem_addr_write;
   logic [ADDR_BITS-1:0] mem_addr_read;
   logic                 mem_write;
   logic                 mem_read;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_out_valid;
   logic                 full;
   logic                 empty;
   logic                 almost_full;
   logic                 almost_empty;
   logic [ADDR_BITS:0]   fifo_count;
   logic                 error;

   modport master (
      output push, pop, data_in, mem_data_out,
      input  mem_data_in, mem_addr_write, mem_addr_read, mem_write, mem_read,
      input  data_out, data_out_valid, full, empty, almost_full, almost_empty,
      input  fifo_count, error
   );

   modport slave (
      input  push, pop, data_in, mem_data_out,
      output mem_data_in, mem_addr_write, mem_addr_read, mem_write, mem_read,
      output data_out, data_out_valid, full, empty, almost_full, almost_empty,
      output fifo_count, error
   );
endinterface

// File: rtl/fifo_mem_ctrl.sv
// Pointer/status controller for a FIFO held in an external memory with one-cycle read latency.
// Define FIFO_MEM_CTRL_ERR_EN to enable the sticky overflow/underflow error flag.
module fifo_mem_ctrl #(
   parameter int unsigned DATA_BITS       = 8,
   parameter int unsigned ADDR_BITS       = 6,
   parameter int unsigned ALMOST_FULL_TH  = (1 << ADDR_BITS) - 2,
   parameter int unsigned ALMOST_EMPTY_TH = 2
) (
   input logic            clk,
   input logic            reset_L,
   fifo_mem_ctrl_if.slave bus
);
   localparam int unsigned CNT_BITS = ADDR_BITS + 1;
   localparam int unsigned DEPTH    = 1 << ADDR_BITS;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [ADDR_BITS-1:0] wptr_q, wptr_d;
   logic [ADDR_BITS-1:0] rptr_q, rptr_d;
   logic [CNT_BITS-1:0]  count_q, count_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;
   logic                 push_ok_c, pop_ok_c;
   logic [DATA_BITS-1:0] wdata_c, rdata_c;

   // State register; reset clears pointers, count, read-valid and error.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= ST_EMPTY;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // Request acceptance, pointer/count update and status transitions.
   always_comb begin
      push_ok_c = 1'b0;
      pop_ok_c  = 1'b0;
      state_d   = state_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      count_d   = count_q;
      valid_d   = 1'b0;
      err_d     = err_q;

      // Strobes are gated by reset so nothing reaches memory while it is held.
      if (reset_L) begin
         push_ok_c = bus.push && (state_q != ST_FULL);
         pop_ok_c  = bus.pop  && (state_q != ST_EMPTY);
      end

      if (push_ok_c) wptr_d = wptr_q + ADDR_BITS'(1);
      if (pop_ok_c)  rptr_d = rptr_q + ADDR_BITS'(1);

      if (push_ok_c && !pop_ok_c)      count_d = count_q + CNT_BITS'(1);
      else if (pop_ok_c && !push_ok_c) count_d = count_q - CNT_BITS'(1);

      unique case (state_q)
         ST_EMPTY:   if (push_ok_c) state_d = ST_PARTIAL;
         ST_PARTIAL: begin
            if (count_d == '0)                       state_d = ST_EMPTY;
            else if (count_d == CNT_BITS'(DEPTH))    state_d = ST_FULL;
         end
         ST_FULL:    if (pop_ok_c) state_d = ST_PARTIAL;
         default:    state_d = ST_EMPTY;
      endcase

      valid_d = pop_ok_c;

`ifdef FIFO_MEM_CTRL_ERR_EN
      if (reset_L && ((bus.push && !push_ok_c) || (bus.pop && !pop_ok_c))) err_d = 1'b1;
`else
      err_d = 1'b0;
`endif
   end

   assign wdata_c = bus.data_in;
   assign rdata_c = bus.mem_data_out;

   assign bus.mem_data_in    = wdata_c;
   assign bus.data_out       = rdata_c;
   assign bus.mem_write      = push_ok_c;
   assign bus.mem_read       = pop_ok_c;
   assign bus.mem_addr_write = wptr_q;
   assign bus.mem_addr_read  = rptr_q;
   assign bus.data_out_valid = valid_q;
   assign bus.fifo_count     = count_q;
   assign bus.error          = err_q;
   assign bus.empty          = (state_q == ST_EMPTY);
   assign bus.full           = (state_q == ST_FULL);
   assign bus.almost_full    = (count_q >= CNT_BITS'(ALMOST_FULL_TH));
   assign bus.almost_empty   = (count_q <= CNT_BITS'(ALMOST_EMPTY_TH));
endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Directed bench for fifo_mem_ctrl with a behavioural memory and a data scoreboard.
module tb_fifo_mem_ctrl;
   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 64;

   logic clk = 1'b0;
   logic reset_L;
   always #5 clk = ~clk;

   fifo_mem_ctrl_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

   fifo_mem_ctrl #(.DATA_BITS(DW), .ADDR_BITS(AW)) dut (
      .clk     (clk),
      .reset_L (reset_L),
      .bus     (bus)
   );

   // Synchronous-read memory the controller drives.
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_q;
   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_addr_write] <= bus.mem_data_in;
      if (bus.mem_read)  rd_q <= mem[bus.mem_addr_read];
   end
   assign bus.mem_data_out = rd_q;

   int unsigned   checks = 0;
   int unsigned   errors = 0;
   int unsigned   mcount;
   logic [AW-1:0] mw, mr;
   bit            mpend, merr;
   logic [DW-1:0] sb [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Registered outputs against the model; popped data against the scoreboard.
   task automatic check_state();
      chk("fifo_count", 32'(bus.fifo_count), mcount);
      chk("empty", 32'(bus.empty), 32'(mcount == 0));
      chk("full", 32'(bus.full), 32'(mcount == DEPTH));
      chk("almost_full", 32'(bus.almost_full), 32'(mcount >= DEPTH - 2));
      chk("almost_empty", 32'(bus.almost_empty), 32'(mcount <= 2));
      chk("error", 32'(bus.error), 32'(merr));
      chk("data_out_valid", 32'(bus.data_out_valid), 32'(mpend));
      chk("mem_addr_write", 32'(bus.mem_addr_write), 32'(mw));
      chk("mem_addr_read", 32'(bus.mem_addr_read), 32'(mr));
      if (bus.data_out_valid && sb.size() > 0) chk("data_out", 32'(bus.data_out), 32'(sb.pop_front()));
   endtask

   task automatic drive(input bit p, input bit q, input logic [DW-1:0] d);
      bit acc_push, acc_pop;
      @(negedge clk);
      check_state();
      bus.push = p; bus.pop = q; bus.data_in = d;
      #1;
      acc_push = p && (mcount != DEPTH);
      acc_pop  = q && (mcount != 0);
      chk("mem_write", 32'(bus.mem_write), 32'(acc_push));
      chk("mem_read", 32'(bus.mem_read), 32'(acc_pop));
      chk("mem_data_in", 32'(bus.mem_data_in), 32'(d));
      if (acc_push) begin sb.push_back(d); mw++; mcount++; end
      if (acc_pop)  begin mr++; mcount--; end
      mpend = acc_pop;
`ifdef FIFO_MEM_CTRL_ERR_EN
      if ((p && !acc_push) || (q && !acc_pop)) merr = 1'b1;
`endif
   endtask

   // Assert reset (optionally between edges), check forced values with requests active, release.
   task automatic apply_reset(input bit mid);
      if (mid) begin @(negedge clk); #2; end
      reset_L = 1'b0;
      bus.push = 1'b1; bus.pop = 1'b1; bus.data_in = 8'h5C;
      #1;
      chk("rst_count", 32'(bus.fifo_count), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_almost_empty", 32'(bus.almost_empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_almost_full", 32'(bus.almost_full), 0);
      chk("rst_valid", 32'(bus.data_out_valid), 0);
      chk("rst_error", 32'(bus.error), 0);
      chk("rst_mem_write", 32'(bus.mem_write), 0);
      chk("rst_mem_read", 32'(bus.mem_read), 0);
      chk("rst_addr_write", 32'(bus.mem_addr_write), 0);
      chk("rst_addr_read", 32'(bus.mem_addr_read), 0);
      bus.push = 1'b0; bus.pop = 1'b0;
      mcount = 0; mw = '0; mr = '0; mpend = 1'b0; merr = 1'b0;
      sb.delete();
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   initial begin
      bus.push = 1'b0; bus.pop = 1'b0; bus.data_in = '0;
      apply_reset(1'b0);

      // First push lands at address 0; count/flags follow on the edge.
      drive(1'b1, 1'b0, 8'hFF);
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 8'h00);
      // Pop on empty alongside a push: only the push is taken.
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 8'h5A);
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b0, 8'h00);

      // Ordered read-back of three words.
      drive(1'b1, 1'b0, 8'h11);
      drive(1'b1, 1'b0, 8'h22);
      drive(1'b1, 1'b0, 8'h33);
      repeat (3) drive(1'b0, 1'b1, 8'h00);
      repeat (2) drive(1'b0, 1'b0, 8'h00);

      // Fill to full (write pointer wraps), overflow, then push+pop on full.
      for (int i = 0; i < 64; i++) drive(1'b1, 1'b0, 8'($urandom_range(0, 255)));
      drive(1'b1, 1'b0, 8'hAA);
      drive(1'b1, 1'b1, 8'hBB);
      drive(1'b0, 1'b0, 8'h00);

      // Drain to ten words, then reset mid-cycle and confirm restart at address 0.
      while (mcount > 10) drive(1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      apply_reset(1'b1);
      drive(1'b1, 1'b0, 8'hC3);
      drive(1'b0, 1'b1, 8'h00);
      drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b0, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_mem_ctrl.md
FIFO_MEM_CTRL -- requirements
Module: fifo_mem_ctrl

Interface
REQ-001 Parameter DATA_BITS, default 8: word width passed to the memory.
REQ-002 Parameter ADDR_BITS, default 6: memory address width; DEPTH = 2^ADDR_BITS words.
REQ-003 Parameter ALMOST_FULL_TH, default DEPTH-2: count at or above which almost_full asserts.
REQ-004 Parameter ALMOST_EMPTY_TH, default 2: count at or below which almost_empty asserts.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 reset_L  input  1  reset, asynchronous, active-low.
REQ-007 push  input  1  requester writes data_in this cycle.
REQ-008 pop  input  1  requester reads one word this cycle.
REQ-009 data_in  input  DATA_BITS  write data from requester.
REQ-010 mem_data_out  input  DATA_BITS  registered read data from memory, valid one cycle after mem_read.
REQ-011 mem_data_in  output  DATA_BITS  write data to memory; combinational copy of data_in.
REQ-012 mem_addr_write, mem_addr_read  output  ADDR_BITS each  memory write/read addresses (write/read pointers).
REQ-013 mem_write, mem_read  output  1 each  memory write/read strobes.
REQ-014 data_out  output  DATA_BITS  combinational copy of mem_data_out; data_out_valid  output  1  popped word present on data_out.
REQ-015 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-016 fifo_count  output  ADDR_BITS+1  words stored, 0..DEPTH.
REQ-017 error  output  1  sticky overflow/underflow flag.

Function
REQ-018 Status FSM SHALL have states EMPTY, PARTIAL, FULL; empty=1 only in EMPTY, full=1 only in FULL.
REQ-019 Push accepted iff push=1 and state!=FULL; accepted push SHALL drive mem_write=1 combinationally that cycle and advance write pointer by 1 on the edge.
REQ-020 Pop accepted iff pop=1 and state!=EMPTY; accepted pop SHALL drive mem_read=1 combinationally that cycle and advance read pointer by 1 on the edge.
REQ-021 data_out_valid SHALL be 1 exactly one cycle after each accepted pop (read latency 1).
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 modulo 2^ADDR_BITS.
REQ-023 fifo_count: +1 on accepted push only, -1 on accepted pop only, unchanged on both or neither.
REQ-024 Push when FULL SHALL be rejected even if pop=1 the same cycle (pop still accepted).
REQ-025 Pop when EMPTY SHALL be rejected even if push=1 the same cycle (push still accepted).
REQ-026 Transitions: EMPTY->PARTIAL on accepted push only; PARTIAL->EMPTY when count goes 1->0; PARTIAL->FULL when count goes DEPTH-1->DEPTH; FULL->PARTIAL on accepted pop only; else hold.
REQ-027 almost_full = (fifo_count >= ALMOST_FULL_TH); almost_empty = (fifo_count <= ALMOST_EMPTY_TH); both registered-derived from fifo_count, no extra latency.
REQ-028 Rejected requests SHALL not change pointers, count, FSM, or memory strobes.

Reset
REQ-029 reset_L=0 SHALL immediately force: pointers 0, fifo_count 0, FSM EMPTY, data_out_valid 0, error 0.
REQ-030 During reset mem_write=0 and mem_read=0 regardless of push/pop; flags: empty=1, almost_empty=1, full=0, almost_full=0.
REQ-031 Reset asserted mid-operation SHALL discard all stored words; first accepted push after release writes address 0.

Configuration
REQ-032 Macro FIFO_MEM_CTRL_ERR_EN defined: error SHALL set on the edge after any rejected push or pop and stay 1 until reset.
REQ-033 Macro undefined: error SHALL be constant 0; all other behaviour identical.

Verification
REQ-034 Reset, then push 0xFF -> mem_write=1, mem_addr_write=0; next cycle count=1, empty=0, almost_empty=1.
REQ-035 64 consecutive pushes from empty (ADDR_BITS=6) -> full=1 after 64th edge, count=64, mem_addr_write=0 (wrapped); 65th push -> mem_write=0, error=1 (ERR_EN).
REQ-036 Pop when empty with push=1 -> mem_read=0, push accepted, count=1, data_out_valid=0 next cycle.
REQ-037 Push 0x11,0x22,0x33 then pop x3 -> data_out_valid high 3 cycles, data_out 0x11,0x22,0x33 in order, empty=1 after last.
REQ-038 Full with push=1, pop=1 -> pop accepted, push rejected, count=63, FSM PARTIAL, error=1 (ERR_EN) or 0 (undefined).
REQ-039 Count=10, assert reset_L=0 between edges -> all outputs at reset values immediately; after release push writes address 0.
